// File: rtl/simple_proc_gen.sv
// rtl/simple_proc_gen.sv - parametrised multicycle processor core with run/done handshake
module simple_proc_gen #(
    parameter int REG_WIDTH = 16,
    parameter int NUM_REGS  = 8,
    localparam int RSEL_W   = $clog2(NUM_REGS),
    localparam int INSTR_W  = 4 + 2 * RSEL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [INSTR_W-1:0]            din,
    output logic                          done,
    output logic                          busy,
    output logic [3:0]                    tick_FSM,
    output logic [REG_WIDTH-1:0]          bus,
    output logic [REG_WIDTH-1:0]          display,
    output logic                          flag_z,
    output logic                          flag_n,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_flat
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EX1  = 3'd1;
    localparam logic [2:0] S_EX2  = 3'd2;
    localparam logic [2:0] S_EX3  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] OP_DISP = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_MOVI = 4'd7;
    localparam logic [3:0] OP_MV   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_OR   = 4'd10;
    localparam logic [3:0] OP_XOR  = 4'd11;
    localparam logic [3:0] OP_MVNZ = 4'd12;

    logic [2:0]           state, state_next;
    logic [INSTR_W-1:0]   ir;
    logic [REG_WIDTH-1:0] r [NUM_REGS];
    logic [REG_WIDTH-1:0] a, g, h;
    logic [REG_WIDTH-1:0] imm, g_next;
    logic [3:0]           op;
    logic [RSEL_W-1:0]    rx, ry;
    logic                 is_shift, is_three, is_short;
    logic                 r_we, a_we, g_we, h_we;

    assign op  = ir[INSTR_W-1 -: 4];
    assign rx  = ir[2*RSEL_W-1 -: RSEL_W];
    assign ry  = ir[RSEL_W-1:0];
    assign imm = REG_WIDTH'($signed(din));

    assign is_shift = (op == OP_SRL) || (op == OP_SLL);
    assign is_three = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_MUL) ||
                      (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    assign is_short = !is_shift && !is_three;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (run) state_next = S_EX1;
            S_EX1:   state_next = is_short ? S_DONE : S_EX2;
            S_EX2:   state_next = is_shift ? S_DONE : S_EX3;
            S_EX3:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Every register write takes its data from the bus, so the mux alone defines write data.
    always_comb begin
        bus = r[0];
        case (state)
            S_EX1: begin
                case (op)
                    OP_ADDI, OP_MOVI: bus = imm;
                    OP_MV, OP_MVNZ:   bus = r[ry];
                    OP_DISP, OP_ADD, OP_SUB, OP_MUL, OP_SRL, OP_SLL,
                    OP_AND, OP_OR, OP_XOR: bus = r[rx];
                    default:          bus = r[0];
                endcase
            end
            S_EX2: begin
                if (is_shift)
                    bus = g;
                else if (op == OP_ADDI)
                    bus = r[rx];
                else if (is_three)
                    bus = r[ry];
            end
            S_EX3:   bus = g;
            default: bus = r[0];
        endcase
    end

    always_comb begin
        g_next = g;
        if (state == S_EX1) begin
            g_next = (op == OP_SRL) ? (bus >> ry) : (bus << ry);
        end else begin
            case (op)
                OP_ADD, OP_ADDI: g_next = a + bus;
                OP_SUB:          g_next = a - bus;
                OP_MUL:          g_next = a * bus;
                OP_AND:          g_next = a & bus;
                OP_OR:           g_next = a | bus;
                OP_XOR:          g_next = a ^ bus;
                default:         g_next = g;
            endcase
        end
    end

    assign a_we = (state == S_EX1) && is_three;
    assign h_we = (state == S_EX1) && (op == OP_DISP);
    assign g_we = ((state == S_EX1) && is_shift) || ((state == S_EX2) && is_three);
    assign r_we = ((state == S_EX1) && ((op == OP_MOVI) || (op == OP_MV) ||
                                        ((op == OP_MVNZ) && !flag_z))) ||
                  ((state == S_EX2) && is_shift) ||
                  (state == S_EX3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ir     <= '0;
            a      <= '0;
            g      <= '0;
            h      <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && run)
                ir <= din;
            if (a_we)
                a <= bus;
            if (h_we)
                h <= bus;
            if (g_we) begin
                g      <= g_next;
                flag_z <= (g_next == '0);
                flag_n <= g_next[REG_WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst)
                r[i] <= '0;
            else if (r_we && rx == RSEL_W'(i))
                r[i] <= bus;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[gi*REG_WIDTH +: REG_WIDTH] = r[gi];
    end

    always_comb begin
        case (state)
            S_EX1:   tick_FSM = 4'b0001;
            S_EX2:   tick_FSM = 4'b0010;
            S_EX3:   tick_FSM = 4'b0100;
            S_DONE:  tick_FSM = 4'b1000;
            default: tick_FSM = 4'b0000;
        endcase
    end

    assign done    = (state == S_DONE);
    assign busy    = (state != S_IDLE);
    assign display = h;

endmodule

// File: tb/tb_simple_proc_gen.sv
// tb/tb_simple_proc_gen.sv - scoreboard bench for simple_proc_gen at 16x8 and 32x16
module tb_simple_proc_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         run_a, run_b;
    logic [9:0]   din_a;
    logic [11:0]  din_b;
    logic         done_a, busy_a, z_a, n_a;
    logic         done_b, busy_b, z_b, n_b;
    logic [3:0]   tick_a, tick_b;
    logic [15:0]  bus_a, disp_a;
    logic [31:0]  bus_b, disp_b;
    logic [127:0] regs_a;
    logic [511:0] regs_b;

    always #5 clk = ~clk;

    simple_proc_gen u_dut_a (
        .clk(clk), .rst(rst), .run(run_a), .din(din_a), .done(done_a), .busy(busy_a),
        .tick_FSM(tick_a), .bus(bus_a), .display(disp_a), .flag_z(z_a), .flag_n(n_a),
        .regs_flat(regs_a)
    );

    simple_proc_gen #(.REG_WIDTH(32), .NUM_REGS(16)) u_dut_b (
        .clk(clk), .rst(rst), .run(run_b), .din(din_b), .done(done_b), .busy(busy_b),
        .tick_FSM(tick_b), .bus(bus_b), .display(disp_b), .flag_z(z_b), .flag_n(n_b),
        .regs_flat(regs_b)
    );

    typedef struct {
        int          lat;
        int          rx;
        logic [31:0] val;
        logic        z;
        logic        n;
        logic        is_disp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    bit          sel_b = 1'b0;
    int          cw = 16;
    logic [31:0] mask = 32'h0000_FFFF;
    logic [31:0] m_r [16];
    logic        m_z, m_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] get_reg(input int i);
        return sel_b ? regs_b[i*32 +: 32] : {16'h0, regs_a[i*16 +: 16]};
    endfunction
    function automatic logic f_done();         return sel_b ? done_b : done_a; endfunction
    function automatic logic f_busy();         return sel_b ? busy_b : busy_a; endfunction
    function automatic logic [3:0] f_tick();   return sel_b ? tick_b : tick_a; endfunction
    function automatic logic f_z();            return sel_b ? z_b : z_a;       endfunction
    function automatic logic f_n();            return sel_b ? n_b : n_a;       endfunction
    function automatic logic [31:0] f_disp();  return sel_b ? disp_b : {16'h0, disp_a}; endfunction

    task automatic set_din(input logic [11:0] v);
        if (sel_b) din_b = v;
        else       din_a = v[9:0];
    endtask

    task automatic set_run(input logic v);
        if (sel_b) run_b = v;
        else       run_a = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    // poke: 0 none, 1 pulse run during EX2, 2 assert rst during EX2
    task automatic issue(input logic [3:0] op, input int rx, input int ry, input int imm, input int poke);
        logic [31:0] x, y, im, g;
        logic [3:0]  rx4, ry4;
        logic [11:0] instr;
        bit          gw;
        int          lat, dcnt;
        exp_t        e, got;
        x   = m_r[rx];
        y   = m_r[ry];
        im  = 32'(imm) & mask;
        g   = '0;
        gw  = 1'b0;
        rx4 = 4'(rx);
        ry4 = 4'(ry);
        instr = sel_b ? {op, rx4, ry4} : {2'b00, op, rx4[2:0], ry4[2:0]};
        e.is_disp = (op == 4'd0);
        e.lat = 4;
        case (op)
            4'd0: begin e.lat = 2; e.val = x; end
            4'd1: begin g = x + y; gw = 1'b1; end
            4'd2: begin g = im + x; gw = 1'b1; end
            4'd3: begin g = x - y; gw = 1'b1; end
            4'd4: begin g = x * y; gw = 1'b1; end
            4'd5: begin g = x >> ry; gw = 1'b1; e.lat = 3; end
            4'd6: begin g = x << ry; gw = 1'b1; e.lat = 3; end
            4'd7: begin e.lat = 2; m_r[rx] = im; end
            4'd8: begin e.lat = 2; m_r[rx] = y; end
            4'd9: begin g = x & y; gw = 1'b1; end
            4'd10: begin g = x | y; gw = 1'b1; end
            4'd11: begin g = x ^ y; gw = 1'b1; end
            4'd12: begin e.lat = 2; if (!m_z) m_r[rx] = y; end
            default: e.lat = 2;
        endcase
        if (gw) begin
            g = g & mask;
            m_r[rx] = g;
            m_z = (g == 0);
            m_n = g[cw-1];
        end
        e.rx = rx;
        if (!e.is_disp) e.val = m_r[rx];
        e.z = m_z;
        e.n = m_n;
        if (poke != 2) sb.push_back(e);

        @(negedge clk);
        set_din(instr);
        set_run(1'b1);
        @(posedge clk);
        #1;
        set_run(1'b0);
        if (op == 4'd2 || op == 4'd7) set_din(im[11:0]);
        lat = 1;
        while (!f_done() && lat < 20) begin
            if (lat == 2 && poke == 2) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_clear();
                check("rst_tick", f_tick(), 4'b0000);
                check("rst_busy", f_busy(), 1'b0);
                check("rst_z", f_z(), 1'b0);
                for (int i = 0; i < (sel_b ? 16 : 8); i++) check("rst_reg", get_reg(i), 32'h0);
                dcnt = 0;
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #1;
                    if (f_done()) dcnt++;
                end
                check("rst_no_done", dcnt, 0);
                return;
            end
            if (lat == 2 && poke == 1) set_run(1'b1);
            @(posedge clk);
            #1;
            set_run(1'b0);
            lat++;
        end
        got = sb.pop_front();
        check("latency", lat, got.lat);
        check("tick_done", f_tick(), 4'b1000);
        check("busy_done", f_busy(), 1'b1);
        if (got.is_disp) check("display", f_disp(), got.val);
        else             check("reg", get_reg(got.rx), got.val);
        check("flag_z", f_z(), got.z);
        check("flag_n", f_n(), got.n);
        @(posedge clk);
        #1;
        check("done_pulse", f_done(), 1'b0);
        if (poke == 1) begin
            dcnt = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                if (f_done()) dcnt++;
            end
            check("run_ignored", dcnt, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        run_a = 1'b0;
        run_b = 1'b0;
        din_a = '0;
        din_b = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tick", tick_a, 4'b0000);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_regs", regs_a[31:0], 32'h0);
        check("reset_regs_hi", regs_a[127:96], 32'h0);
        check("reset_disp", disp_a, 16'h0);
        check("reset_flags", {z_a, n_a}, 2'b00);

        issue(4'd7, 0, 0, 5, 0);
        issue(4'd7, 1, 0, -3, 0);
        issue(4'd1, 0, 1, 0, 0);
        issue(4'd7, 2, 0, 7, 0);
        issue(4'd3, 2, 2, 0, 0);
        issue(4'd7, 3, 0, 9, 0);
        issue(4'd12, 3, 2, 0, 0);
        issue(4'd7, 2, 0, 4, 0);
        issue(4'd3, 2, 1, 0, 0);
        issue(4'd12, 3, 2, 0, 0);
        issue(4'd7, 4, 0, 256, 0);
        issue(4'd4, 4, 4, 0, 0);
        issue(4'd7, 6, 0, 256, 0);
        issue(4'd7, 7, 0, 128, 0);
        issue(4'd4, 6, 7, 0, 0);
        issue(4'd7, 5, 0, 1, 0);
        issue(4'd1, 5, 6, 0, 0);
        issue(4'd6, 5, 4, 0, 0);
        issue(4'd5, 5, 1, 0, 0);
        issue(4'd2, 1, 0, 100, 0);
        issue(4'd9, 0, 1, 0, 0);
        issue(4'd10, 7, 1, 0, 0);
        issue(4'd11, 6, 1, 0, 0);
        issue(4'd8, 6, 5, 0, 0);
        issue(4'd13, 6, 0, 0, 0);
        issue(4'd0, 1, 0, 0, 0);
        issue(4'd1, 0, 1, 0, 1);
        issue(4'd1, 0, 1, 0, 2);
        issue(4'd7, 0, 0, 3, 0);

        sel_b = 1'b1;
        cw = 32;
        mask = 32'hFFFF_FFFF;
        model_clear();
        issue(4'd7, 15, 0, -1, 0);
        issue(4'd7, 9, 0, 3, 0);
        issue(4'd1, 15, 9, 0, 0);
        issue(4'd7, 12, 0, -2048, 0);
        issue(4'd6, 12, 15, 0, 0);
        issue(4'd4, 12, 9, 0, 0);
        issue(4'd5, 12, 12, 0, 0);
        issue(4'd3, 9, 9, 0, 0);
        issue(4'd12, 10, 12, 0, 0);
        issue(4'd0, 12, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
